// File: rtl/clmul_divider_if.sv
// Request/response bundle for the carry-less polynomial divider.
// slave is the divider's view, master is the requester/consumer's view.
interface clmul_divider_if #(
  parameter int WIDTH = 64
);
  logic             flush_i;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic             is_32_bit_mode_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;
  logic             div_by_zero_o;

  modport slave (
    input  flush_i, valid_i, dividend_i, divisor_i, is_32_bit_mode_i, ready_i,
    output ready_o, valid_o, quotient_o, remainder_o, div_by_zero_o
  );

  modport master (
    output flush_i, valid_i, dividend_i, divisor_i, is_32_bit_mode_i, ready_i,
    input  ready_o, valid_o, quotient_o, remainder_o, div_by_zero_o
  );
endinterface

// File: rtl/clmul_divider.sv
// Iterative GF(2)[x] divider: one quotient bit per cycle, valid/ready on both sides.
//   state | meaning
//   IDLE  | ready for a request
//   BUSY  | shifting dividend bits MSB-first through the remainder
//   DONE  | result presented, waiting for ready_i
module clmul_divider #(
  parameter int WIDTH = 64
) (
  input logic            clk_i,
  input logic            rst_i,
  clmul_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    d_idx_q, d_idx_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] a_eff, b_eff, r_shift;
  logic [CW-1:0]    lead;
  logic             valid_int;

  always_comb begin
    a_eff = bus.dividend_i;
    b_eff = bus.divisor_i;
    if (bus.is_32_bit_mode_i) begin
      a_eff[WIDTH-1:32] = '0;
      b_eff[WIDTH-1:32] = '0;
    end
  end

  // Leading-one encoder: the highest set bit wins because it is visited last.
  always_comb begin
    lead = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (b_eff[i]) lead = CW'(i);
    end
  end

  assign r_shift = {rem_q[WIDTH-2:0], dividend_q[cnt_q]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      d_idx_q    <= '0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      d_idx_q    <= d_idx_d;
      dbz_q      <= dbz_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    d_idx_d    = d_idx_q;
    dbz_d      = dbz_q;

    if (bus.flush_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.valid_i) begin
            dividend_d = a_eff;
            divisor_d  = b_eff;
            d_idx_d    = lead;
            cnt_d      = bus.is_32_bit_mode_i ? CW'(31) : CW'(WIDTH - 1);
            quo_d      = '0;
            if (b_eff == '0) begin
              rem_d   = a_eff;
              dbz_d   = 1'b1;
              state_d = DONE;
            end else begin
              rem_d   = '0;
              dbz_d   = 1'b0;
              state_d = BUSY;
            end
          end
        end
        BUSY: begin
          quo_d = {quo_q[WIDTH-2:0], r_shift[d_idx_q]};
          rem_d = r_shift[d_idx_q] ? (r_shift ^ divisor_q) : r_shift;
          if (cnt_q == '0) state_d = DONE;
          else             cnt_d   = cnt_q - 1'b1;
        end
        DONE: begin
          if (bus.ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign valid_int         = (state_q == DONE);
  assign bus.ready_o       = (state_q == IDLE);
  assign bus.valid_o       = valid_int;
  assign bus.quotient_o    = quo_q;
  assign bus.remainder_o   = rem_q;
  assign bus.div_by_zero_o = dbz_q;

  // A presented result must not move while the consumer stalls.
  hold_stable: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (valid_int && !bus.ready_i && !bus.flush_i) |=>
      (valid_int && $stable(quo_q) && $stable(rem_q) && $stable(dbz_q))
  );
endmodule
